debounce_array: RTL and testbench
=================================

# debounce_array

Parametrised, multi-channel pushbutton/switch debouncer with per-channel rise/fall one-pulse outputs. Each channel synchronises its raw input, requires `STABLE` consecutive sampling ticks of disagreement before the debounced level changes, and emits a single-cycle edge pulse when the level changes. It sits between the FPGA board's raw buttons/switches and the control FSMs. It is clocked by the system clock, with sampling rate set by an external tick (e.g. a 100 Hz enable from the clock divider).

## Interface
- `CH`, 4 — number of independent channels (≥1)
- `STABLE`, 4 — consecutive ticks of disagreement required to change level (≥1)
- `RESET_VAL`, 1'b0 — debounced level, and synchroniser contents, after reset (applies to all channels)
- `clk`  input  1  system clock, all logic on rising edge
- `rst_n`  input  1  asynchronous, active-low reset
- `tick_en`  input  1  sampling enable; counters advance only on cycles where it is high
- `pb`  input  CH  raw asynchronous button/switch levels
- `pb_db`  output  CH  debounced levels
- `pb_rise`  output  CH  one-cycle pulse when `pb_db[i]` goes 0→1
- `pb_fall`  output  CH  one-cycle pulse when `pb_db[i]` goes 1→0

## Operation
- Per channel, with no coupling between channels:
  - two-flop synchroniser `s1`, `s2`, clocked every `clk` regardless of `tick_en`;
  - counter `cnt`, width `CNT_W = max(1, clog2(STABLE))`;
  - registered level `db`.
- On a `tick_en` cycle:
  - `s2 == db` → `cnt <= 0`. A bounce back to the old level discards progress.
  - `s2 != db` and `cnt < STABLE-1` → `cnt <= cnt+1`.
  - `s2 != db` and `cnt == STABLE-1` → `db <= s2`, `cnt <= 0`. Assert `pb_rise` or `pb_fall` per the new value.
- On a non-tick cycle: `cnt` and `db` hold. `pb_rise` and `pb_fall` are 0.
- Pulses are registered and high for exactly one `clk` cycle per level change. `pb_rise` and `pb_fall` are never both high on the same channel.
- Behaviour is symmetric: press and release need the same `STABLE` ticks.
- `STABLE=1`: the level follows `s2` on the first mismatching tick.
- `cnt` never exceeds `STABLE-1`. No wrap is possible.

## Timing
- Reset (async assert, released synchronously by the board): `s1 = s2 = db = RESET_VAL`, `cnt = 0`, `pb_rise = pb_fall = 0`. No edge pulse is emitted after reset release, even if `pb` differs from `RESET_VAL`.
- Reset mid-count discards all progress.
- Latency with `tick_en` tied high: `pb` stable before edge 0 → `s2` valid after edge 1 → mismatching ticks at edges 2 … STABLE+1 → `pb_db` and pulse change after edge STABLE+1. That is STABLE+2 clocks total.
- Latency with a sparse tick: 2 clocks of synchronisation, then `STABLE` ticks. The level updates on the `clk` edge of the `STABLE`-th tick.
- The pulse coincides with the first cycle of the new `pb_db` value.
- Simultaneous changes on several channels are handled independently, with identical latency.

## Structure
- Shared package `debounce_pkg`:
  - `clog2` function;
  - `CNT_W` derivation;
  - default `STABLE` constant (4 ticks at 100 Hz ≈ 40 ms).
- Sub-module `debounce_ch`: one channel with parameters `STABLE` and `RESET_VAL`. Ports are `clk`, `rst_n`, `tick_en`, `pb`, `db`, `rise`, `fall`.
- `debounce_array` is a generate loop of `CH` instances of `debounce_ch`, with no other logic.

## Test plan
- Reset check: CH=4, STABLE=4, RESET_VAL=0, `pb=4'b1111` held through reset release.
  - `pb_db=0`, no pulses during reset.
  - First `pb_rise=4'b1111` exactly STABLE+2 clocks after release (tick tied high), then a single-cycle pulse.
- Clean press/release on ch0, tick tied high: `pb[0]` 0→1.
  - `pb_db[0]` rises after 6 clocks, with `pb_rise[0]` for 1 cycle.
  - Release after 20 clocks: `pb_fall[0]` 6 clocks later, 1 cycle.
- Bounce on ch1: `pb[1]` toggles 1,0,1,0 on successive ticks, then holds 1.
  - No change until 4 consecutive mismatching ticks after the last 0.
  - Exactly one `pb_rise[1]`.
- Sparse tick: `tick_en` high 1 cycle in 10, STABLE=4, `pb[2]` 0→1.
  - `pb_db[2]` changes on the 4th tick after synchronisation.
  - `cnt` holds between ticks, verified by glitching `pb` only on non-tick cycles: no effect.
- Independence and corner cases:
  - ch0 rises while ch3 falls on the same cycle: both pulses at the same latency, other channels quiet.
  - Asserting `rst_n` low mid-count (cnt=2) clears state, and no pulse follows release.
  - Repeat the suite with STABLE=1.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the multi-channel debouncer.
package debounce_pkg;

  // 4 ticks at a 100 Hz sampling rate is roughly 40 ms
  localparam int unsigned DEFAULT_STABLE = 4;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned v = 1; v < value; v = v << 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned stable);
    return (clog2(stable) < 1) ? 1 : clog2(stable);
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: 2-flop synchroniser, tick-qualified stability counter,
// registered level and single-cycle rise/fall pulses.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE    = DEFAULT_STABLE,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_en,
  input  logic pb,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam int unsigned      CNT_W   = cnt_w(STABLE);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= RESET_VAL;
      s2 <= RESET_VAL;
    end else begin
      s1 <= pb;
      s2 <= s1;
    end
  end

  // Any agreeing tick discards progress, so a bounce restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      db   <= RESET_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (tick_en) begin
        if (s2 == db) begin
          cnt <= '0;
        end else if (cnt == CNT_MAX) begin
          cnt  <= '0;
          db   <= s2;
          rise <= s2;
          fall <= ~s2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/debounce_array.sv
// CH independent debounce channels sharing clock, reset and sampling tick.
module debounce_array
  import debounce_pkg::*;
#(
  parameter int unsigned CH        = 4,
  parameter int unsigned STABLE    = DEFAULT_STABLE,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick_en,
  input  logic [CH-1:0] pb,
  output logic [CH-1:0] pb_db,
  output logic [CH-1:0] pb_rise,
  output logic [CH-1:0] pb_fall
);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    debounce_ch #(
      .STABLE    (STABLE),
      .RESET_VAL (RESET_VAL)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick_en (tick_en),
      .pb      (pb[i]),
      .db      (pb_db[i]),
      .rise    (pb_rise[i]),
      .fall    (pb_fall[i])
    );
  end

endmodule

// File: tb/tb_debounce_array.sv
// Bench for debounce_array: STABLE=4 and STABLE=1 instances driven in parallel
// and compared against a sample-window reference model.
module tb_debounce_array;

  localparam int unsigned CH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick_en = 1'b0;
  logic [CH-1:0] pb = '0;
  logic [CH-1:0] db4, rise4, fall4, db1, rise1, fall1;

  always #5 clk = ~clk;

  debounce_array #(.CH(CH), .STABLE(4), .RESET_VAL(1'b0)) dut4 (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .pb(pb),
    .pb_db(db4), .pb_rise(rise4), .pb_fall(fall4)
  );

  debounce_array #(.CH(CH), .STABLE(1), .RESET_VAL(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .pb(pb),
    .pb_db(db1), .pb_rise(rise1), .pb_fall(fall1)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: level flips once the last STABLE tick samples all disagree.
  int unsigned   stab [2] = '{4, 1};
  bit            m_s1 [2][CH];
  bit            m_s2 [2][CH];
  bit            m_lvl[2][CH];
  bit            hist [2][CH][4];
  int            nhist[2][CH];
  logic [CH-1:0] m_db  [2];
  logic [CH-1:0] m_rise[2];
  logic [CH-1:0] m_fall[2];

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_db[c] = '0; m_rise[c] = '0; m_fall[c] = '0;
      for (int i = 0; i < CH; i++) begin
        m_s1[c][i] = 1'b0; m_s2[c][i] = 1'b0; m_lvl[c][i] = 1'b0;
        nhist[c][i] = 0;
      end
    end
  endtask

  task automatic model_edge();
    bit all_differ;
    for (int c = 0; c < 2; c++) begin
      m_rise[c] = '0; m_fall[c] = '0;
      for (int i = 0; i < CH; i++) begin
        if (tick_en) begin
          for (int k = 3; k > 0; k--) hist[c][i][k] = hist[c][i][k-1];
          hist[c][i][0] = m_s2[c][i];
          if (nhist[c][i] < 4) nhist[c][i]++;
          all_differ = (nhist[c][i] >= int'(stab[c]));
          for (int k = 0; k < int'(stab[c]); k++)
            if (hist[c][i][k] == m_lvl[c][i]) all_differ = 1'b0;
          if (all_differ) begin
            m_lvl[c][i] = ~m_lvl[c][i];
            if (m_lvl[c][i]) m_rise[c][i] = 1'b1;
            else             m_fall[c][i] = 1'b1;
          end
        end
        m_s2[c][i] = m_s1[c][i];
        m_s1[c][i] = pb[i];
        m_db[c][i] = m_lvl[c][i];
      end
    end
  endtask

  task automatic chk(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic cmp_model();
    chk("s4_db",   db4,   m_db[0]);
    chk("s4_rise", rise4, m_rise[0]);
    chk("s4_fall", fall4, m_fall[0]);
    chk("s1_db",   db1,   m_db[1]);
    chk("s1_rise", rise1, m_rise[1]);
    chk("s1_fall", fall1, m_fall[1]);
  endtask

  task automatic step(input logic [CH-1:0] p, input logic t);
    pb = p;
    tick_en = t;
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    cmp_model();
  endtask

  task automatic do_reset(input logic [CH-1:0] p, input int n);
    pb = p;
    rst_n = 1'b0;
    model_reset();
    #1;
    cmp_model();
    repeat (n) begin
      @(posedge clk);
      #1;
      cmp_model();
    end
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit            rst;
    bit            tick;
    logic [CH-1:0] pb;
    logic [CH-1:0] db;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
  } vec_t;

  vec_t vec[17];

  initial begin
    int r4, r1, f4, f1, cnt4, j;
    logic [CH-1:0] p;

    // Reset with all buttons held, then release of ch0 (STABLE=4 expectations).
    vec[0]  = '{0, 1, 4'hF, 4'h0, 4'h0, 4'h0};
    vec[1]  = '{0, 1, 4'hF, 4'h0, 4'h0, 4'h0};
    for (int k = 2; k <= 6; k++) vec[k] = '{1, 1, 4'hF, 4'h0, 4'h0, 4'h0};
    vec[7]  = '{1, 1, 4'hF, 4'hF, 4'hF, 4'h0};
    vec[8]  = '{1, 1, 4'hF, 4'hF, 4'h0, 4'h0};
    vec[9]  = '{1, 1, 4'hF, 4'hF, 4'h0, 4'h0};
    for (int k = 10; k <= 14; k++) vec[k] = '{1, 1, 4'hE, 4'hF, 4'h0, 4'h0};
    vec[15] = '{1, 1, 4'hE, 4'hE, 4'h0, 4'h1};
    vec[16] = '{1, 1, 4'hE, 4'hE, 4'h0, 4'h0};

    model_reset();
    #2;
    for (int k = 0; k < 17; k++) begin
      rst_n = vec[k].rst;
      if (!vec[k].rst) model_reset();
      step(vec[k].pb, vec[k].tick);
      chk($sformatf("vec%0d_db", k),   db4,   vec[k].db);
      chk($sformatf("vec%0d_rise", k), rise4, vec[k].rise);
      chk($sformatf("vec%0d_fall", k), fall4, vec[k].fall);
    end

    // Bounce on ch1: 1,0,1,0 on successive ticks then hold 1; one rise only.
    do_reset('0, 2);
    cnt4 = 0; r4 = -1;
    for (int k = 0; k < 4; k++) begin
      step((k % 2 == 0) ? 4'b0010 : 4'b0000, 1'b1);
      if (rise4[1]) cnt4++;
    end
    for (int k = 0; k < 12; k++) begin
      step(4'b0010, 1'b1);
      if (rise4[1]) begin cnt4++; if (r4 < 0) r4 = k; end
    end
    chk("bounce_rise_count", 4'(cnt4), 4'd1);
    chk("bounce_rise_cycle", 4'(r4), 4'd5);

    // Sparse tick (1 in 10), ch2 press, ch0 glitches only between ticks.
    do_reset('0, 2);
    r4 = -1; r1 = -1; cnt4 = 0;
    for (j = 0; j < 60; j++) begin
      p = 4'b0100;
      if (j % 10 == 3) p[0] = 1'b1;
      step(p, (j % 10 == 0));
      if (rise4[2] && r4 < 0) r4 = j;
      if (rise1[2] && r1 < 0) r1 = j;
      if (rise4[0] || rise1[0]) cnt4++;
    end
    chk("sparse_s4_cycle", 8'(r4), 8'd40);
    chk("sparse_s1_cycle", 8'(r1), 8'd10);
    chk("sparse_glitch_pulses", 4'(cnt4), 4'd0);

    // ch0 rises while ch3 falls on the same cycle.
    do_reset(4'b1000, 2);
    for (int k = 0; k < 8; k++) step(4'b1000, 1'b1);
    r4 = -1; f4 = -1; r1 = -1; f1 = -1; cnt4 = 0;
    for (j = 0; j < 10; j++) begin
      step(4'b0001, 1'b1);
      if (rise4[0] && r4 < 0) r4 = j;
      if (fall4[3] && f4 < 0) f4 = j;
      if (rise1[0] && r1 < 0) r1 = j;
      if (fall1[3] && f1 < 0) f1 = j;
      if ((rise4 | fall4) & 4'b0110) cnt4++;
    end
    chk("simul_s4_rise0", 4'(r4), 4'd5);
    chk("simul_s4_fall3", 4'(f4), 4'd5);
    chk("simul_s1_rise0", 4'(r1), 4'd2);
    chk("simul_s1_fall3", 4'(f1), 4'd2);
    chk("simul_quiet", 4'(cnt4), 4'd0);

    // Reset mid-count (cnt=2 on ch1): progress is discarded.
    do_reset('0, 2);
    for (int k = 0; k < 4; k++) step(4'b0010, 1'b1);
    chk("midcnt_db_before", db4, 4'b0000);
    do_reset(4'b0010, 2);
    r4 = -1;
    for (j = 0; j < 10; j++) begin
      step(4'b0010, 1'b1);
      if (rise4[1] && r4 < 0) r4 = j;
    end
    chk("midcnt_rise_cycle", 4'(r4), 4'd5);

    // Randomised traffic against the model.
    do_reset('0, 2);
    p = '0;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < CH; i++)
        if ($urandom_range(5) == 0) p[i] = ~p[i];
      if ($urandom_range(499) == 0) begin
        do_reset(p, $urandom_range(1, 3));
      end else begin
        step(p, ($urandom_range(1) == 1));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
